// File: rtl/gl_decode_pkg.sv
`default_nettype none
// ============================================================================
// Module : gl_decode_pkg
// Desc   : Opcode constants, decode states and opcode helper functions
//          shared by the gl_decode stage and its operand buffer.
// Rev    : 1.0
// ============================================================================
package gl_decode_pkg;

    localparam int c_CNT_W = 5;

    localparam logic [7:0] c_OP_NOP        = 8'h00;
    localparam logic [7:0] c_OP_VERTEX     = 8'h03;
    localparam logic [7:0] c_OP_COLOR      = 8'h04;
    localparam logic [7:0] c_OP_CTRL_11    = 8'h11;
    localparam logic [7:0] c_OP_LOADMATRIX = 8'h13;
    localparam logic [7:0] c_OP_CTRL_16    = 8'h16;
    localparam logic [7:0] c_OP_CTRL_17    = 8'h17;
    localparam logic [7:0] c_OP_CTRL_18    = 8'h18;
    localparam logic [7:0] c_OP_CTRL_19    = 8'h19;
    localparam logic [7:0] c_OP_CTRL_1A    = 8'h1A;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    function automatic logic [c_CNT_W-1:0] op_count(input logic [7:0] op);
        case (op)
            c_OP_VERTEX,
            c_OP_COLOR:      op_count = 5'd3;
            c_OP_LOADMATRIX: op_count = 5'd16;
            default:         op_count = 5'd0;
        endcase
    endfunction

    function automatic logic op_known(input logic [7:0] op);
        case (op)
            c_OP_NOP, c_OP_VERTEX, c_OP_COLOR, c_OP_CTRL_11, c_OP_LOADMATRIX,
            c_OP_CTRL_16, c_OP_CTRL_17, c_OP_CTRL_18, c_OP_CTRL_19,
            c_OP_CTRL_1A: op_known = 1'b1;
            default:      op_known = 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/gl_decode_if.sv
`default_nettype none
// ============================================================================
// Module : gl_decode_if
// Desc   : Packet handshake from gl_decode to the transform/execute stage.
// Rev    : 1.0
// ============================================================================
interface gl_decode_if
    import gl_decode_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MAX_OPS = 16
);
    logic                     out_valid;
    logic                     out_ready;
    logic [WIDTH-1:0]         out_inst;
    logic [c_CNT_W-1:0]       out_count;
    logic [MAX_OPS*WIDTH-1:0] out_operands;

    modport master (
        output out_valid,
        output out_inst,
        output out_count,
        output out_operands,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_inst,
        input  out_count,
        input  out_operands,
        output out_ready
    );
endinterface
`default_nettype wire

// File: rtl/gl_decode_operand_buf.sv
`default_nettype none
// ============================================================================
// Module : gl_operand_buf
// Desc   : MAX_OPS x WIDTH operand register file, indexed write, synchronous
//          clear and flat parallel read.
// Rev    : 1.0
// ============================================================================
module gl_operand_buf
    import gl_decode_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MAX_OPS = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_clr,
    input  logic                     i_we,
    input  logic [c_CNT_W-1:0]       i_idx,
    input  logic [WIDTH-1:0]         i_data,
    output logic [MAX_OPS*WIDTH-1:0] o_flat
);

    for (genvar g = 0; g < MAX_OPS; g++) begin : g_slot
        logic [WIDTH-1:0] r_word;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_word <= '0;
            end else if (i_clr) begin
                r_word <= '0;
            end else if (i_we && (i_idx == c_CNT_W'(g))) begin
                r_word <= i_data;
            end
        end

        assign o_flat[g*WIDTH +: WIDTH] = r_word;
    end

endmodule
`default_nettype wire

// File: rtl/gl_decode.sv
`default_nettype none
// ============================================================================
// Module : gl_decode
// Desc   : GL command decode stage: captures fetched instructions, gathers
//          operand words from BRAM and emits one packet per command.
//          Optional sticky unknown-opcode flag under GL_DECODE_ERR_EN.
// Rev    : 1.0
// ============================================================================
module gl_decode
    import gl_decode_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MAX_OPS = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] inst_in,
    input  logic [WIDTH-1:0] bram_base,
    output logic [WIDTH-1:0] bram_addr,
    input  logic [WIDTH-1:0] bram_data,
    output logic             stall_out,
    gl_decode_if.master      out_if
`ifdef GL_DECODE_ERR_EN
    ,
    output logic             err
`endif
);

    state_t                   r_state;
    logic                     r_stall_q;
    logic                     r_hold;
    logic                     r_rd_vld;
    logic                     r_out_valid;
    logic [WIDTH-1:0]         r_inst;
    logic [WIDTH-1:0]         r_base;
    logic [WIDTH-1:0]         r_last_addr;
    logic [WIDTH-1:0]         r_out_inst;
    logic [c_CNT_W-1:0]       r_n;
    logic [c_CNT_W-1:0]       r_k;
    logic [c_CNT_W-1:0]       r_j;
    logic [c_CNT_W-1:0]       r_out_count;
`ifdef GL_DECODE_ERR_EN
    logic                     r_err;
`endif

    logic [7:0]               w_op;
    logic [c_CNT_W-1:0]       w_cnt;
    logic                     w_free;
    logic                     w_cap;
    logic                     w_issue;
    logic                     w_clr;
    logic [WIDTH-1:0]         w_addr;
    logic [MAX_OPS*WIDTH-1:0] w_ops;

    assign w_op    = inst_in[7:0];
    assign w_cnt   = op_count(w_op);
    assign w_free  = !r_out_valid || out_if.out_ready;
    // r_hold blocks the first edge after reset; r_stall_q drops the stale word after a stall
    assign w_cap   = (r_state == ST_IDLE) && !r_stall_q && !r_hold && w_free;
    assign w_issue = (r_state == ST_READ) && (r_k < r_n);
    assign w_addr  = r_base + (WIDTH'(r_k) << 2);
    assign w_clr   = w_cap && (w_op != c_OP_NOP);

    assign bram_addr = w_issue ? w_addr : r_last_addr;
    assign stall_out = (r_state != ST_IDLE)
                     || (w_cap && (w_cnt != '0))
                     || (r_out_valid && !out_if.out_ready);

    // Every accepted command starts from a zeroed buffer so short packets carry no leftovers
    gl_operand_buf #(
        .WIDTH   (WIDTH),
        .MAX_OPS (MAX_OPS)
    ) u_operand_buf (
        .clk    (clk),
        .rst    (reset),
        .i_clr  (w_clr),
        .i_we   (r_rd_vld),
        .i_idx  (r_j),
        .i_data (bram_data),
        .o_flat (w_ops)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_stall_q   <= 1'b0;
            r_hold      <= 1'b1;
            r_rd_vld    <= 1'b0;
            r_out_valid <= 1'b0;
            r_inst      <= '0;
            r_base      <= '0;
            r_last_addr <= '0;
            r_out_inst  <= '0;
            r_n         <= '0;
            r_k         <= '0;
            r_j         <= '0;
            r_out_count <= '0;
`ifdef GL_DECODE_ERR_EN
            r_err       <= 1'b0;
`endif
        end else begin
            r_hold    <= 1'b0;
            r_stall_q <= stall_out;
            r_rd_vld  <= w_issue;
            if (w_issue) begin
                r_k         <= r_k + 5'd1;
                r_last_addr <= w_addr;
            end

            case (r_state)
                ST_IDLE: begin
                    if (r_out_valid && out_if.out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                    if (w_clr) begin
`ifdef GL_DECODE_ERR_EN
                        if (!op_known(w_op)) begin
                            r_err <= 1'b1;
                        end
`endif
                        if (w_cnt == '0) begin
                            r_out_valid <= 1'b1;
                            r_out_inst  <= inst_in;
                            r_out_count <= '0;
                        end else begin
                            r_inst  <= inst_in;
                            r_base  <= bram_base;
                            r_n     <= w_cnt;
                            r_k     <= '0;
                            r_j     <= '0;
                            r_state <= ST_READ;
                        end
                    end
                end

                ST_READ: begin
                    if (r_rd_vld) begin
                        r_j <= r_j + 5'd1;
                        if (r_j == (r_n - 5'd1)) begin
                            r_out_valid <= 1'b1;
                            r_out_inst  <= r_inst;
                            r_out_count <= r_n;
                            r_state     <= ST_OUT;
                        end
                    end
                end

                ST_OUT: begin
                    if (out_if.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign out_if.out_valid    = r_out_valid;
    assign out_if.out_inst     = r_out_inst;
    assign out_if.out_count    = r_out_count;
    assign out_if.out_operands = w_ops;
`ifdef GL_DECODE_ERR_EN
    assign err = r_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gl_decode.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : tb_gl_decode
// Desc   : Scoreboard bench for gl_decode with a timing-level reference model.
// Rev    : 1.0
// ============================================================================
module tb_gl_decode;
    localparam int W = 32;
    localparam int M = 16;

    logic         clk       = 1'b0;
    logic         reset     = 1'b1;
    logic [W-1:0] inst_in   = '0;
    logic [W-1:0] bram_base = '0;
    logic [W-1:0] bram_data = '0;
    logic [W-1:0] bram_addr;
    logic         stall_out;
`ifdef GL_DECODE_ERR_EN
    logic         err;
`endif

    gl_decode_if #(.WIDTH(W), .MAX_OPS(M)) ifc ();

    gl_decode #(.WIDTH(W), .MAX_OPS(M)) dut (
        .clk       (clk),
        .reset     (reset),
        .inst_in   (inst_in),
        .bram_base (bram_base),
        .bram_addr (bram_addr),
        .bram_data (bram_data),
        .stall_out (stall_out),
        .out_if    (ifc)
`ifdef GL_DECODE_ERR_EN
        ,
        .err       (err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct { logic [W-1:0] inst; logic [4:0] cnt; logic [M*W-1:0] ops; } pkt_t;
    typedef struct { logic [W-1:0] inst; logic [W-1:0] base; } fetch_t;

    pkt_t   exp_q[$];
    fetch_t fq[$];
    int     n_chk = 0;
    int     n_fail = 0;

    // Reference model state: cycles since an operand command was accepted
    int           rd_t = -1;
    int           rd_n = 0;
    logic [W-1:0] rd_base = '0;
    bit           m_valid = 1'b0;
    bit           m_stq = 1'b0;
    bit           m_hold = 1'b1;
    bit           m_err = 1'b0;

    int  hold_cnt = 0;
    bit  rnd_ready = 1'b0;

    bit             held = 1'b0;
    logic [W-1:0]   sv_inst;
    logic [4:0]     sv_cnt;
    logic [M*W-1:0] sv_ops;

    function automatic logic [W-1:0] memf(input logic [W-1:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hA5C3_0F17;
    endfunction

    function automatic int nops(input logic [7:0] op);
        if (op == 8'h03 || op == 8'h04) return 3;
        if (op == 8'h13) return 16;
        return 0;
    endfunction

    function automatic bit known(input logic [7:0] op);
        return op inside {8'h00, 8'h03, 8'h04, 8'h11, 8'h13, 8'h16, 8'h17, 8'h18, 8'h19, 8'h1A};
    endfunction

    task automatic check(input string name, input logic [M*W-1:0] act, input logic [M*W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // BRAM with one cycle of read latency
    always @(posedge clk) bram_data <= memf(bram_addr);

    // Reference model: predicts handshake/stall/address per cycle, pushes expected packets
    always @(negedge clk) begin
        logic [7:0] op;
        int   n;
        bit   busy, cap, es;
        pkt_t p;
        if (reset) begin
            check("rst_out_valid", ifc.out_valid, 0);
            check("rst_stall_out", stall_out, 0);
            check("rst_bram_addr", bram_addr, 0);
            check("rst_out_inst", ifc.out_inst, 0);
            check("rst_out_count", ifc.out_count, 0);
            check("rst_out_operands", ifc.out_operands, 0);
`ifdef GL_DECODE_ERR_EN
            check("rst_err", err, 0);
`endif
            rd_t = -1; m_valid = 0; m_stq = 0; m_hold = 1; m_err = 0;
            exp_q.delete();
        end else begin
            op   = inst_in[7:0];
            n    = nops(op);
            busy = (rd_t >= 0);
            cap  = !busy && !m_stq && !m_hold && (!m_valid || ifc.out_ready);
            es   = busy || (cap && n > 0) || (m_valid && !ifc.out_ready);
            check("out_valid", ifc.out_valid, m_valid);
            check("stall_out", stall_out, es);
            if (busy && rd_t <= rd_n)
                check("bram_addr", bram_addr, rd_base + 32'(4 * ((rd_t < rd_n) ? rd_t : rd_n - 1)));
`ifdef GL_DECODE_ERR_EN
            check("err", err, m_err);
`endif
            if (busy) begin
                if (rd_t == rd_n) begin
                    m_valid = 1; rd_t++;
                end else if (rd_t == rd_n + 1) begin
                    if (ifc.out_ready) begin m_valid = 0; rd_t = -1; end
                end else begin
                    rd_t++;
                end
            end else begin
                if (m_valid && ifc.out_ready) m_valid = 0;
                if (cap && op != 8'h00) begin
                    if (!known(op)) m_err = 1;
                    p.inst = inst_in;
                    p.cnt  = 5'(n);
                    p.ops  = '0;
                    for (int k = 0; k < n; k++) p.ops[k*W +: W] = memf(bram_base + 32'(4 * k));
                    exp_q.push_back(p);
                    if (n == 0) m_valid = 1;
                    else begin rd_t = 0; rd_n = n; rd_base = bram_base; end
                end
            end
            m_stq  = es;
            m_hold = 0;
        end
    end

    // Monitor: compares each accepted packet against the scoreboard
    always @(negedge clk) begin
        pkt_t p;
        if (reset) begin
            held = 0;
        end else begin
            if (held && ifc.out_valid) begin
                check("hold_inst", ifc.out_inst, sv_inst);
                check("hold_count", ifc.out_count, sv_cnt);
                check("hold_operands", ifc.out_operands, sv_ops);
            end
            if (ifc.out_valid && ifc.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL pkt_unexpected: got inst %0h expected no packet", ifc.out_inst);
                end else begin
                    p = exp_q.pop_front();
                    check("pkt_inst", ifc.out_inst, p.inst);
                    check("pkt_count", ifc.out_count, p.cnt);
                    check("pkt_operands", ifc.out_operands, p.ops);
                end
            end
            held    = ifc.out_valid && !ifc.out_ready;
            sv_inst = ifc.out_inst;
            sv_cnt  = ifc.out_count;
            sv_ops  = ifc.out_operands;
        end
    end

    task automatic present();
        if (fq.size() > 0) begin inst_in = fq[0].inst; bram_base = fq[0].base; end
        else begin inst_in = '0; bram_base = '0; end
    endtask

    task automatic push(input logic [W-1:0] inst, input logic [W-1:0] base);
        fetch_t f;
        f.inst = inst; f.base = base;
        fq.push_back(f);
        present();
    endtask

    // Fetch behaviour: advance past the presented word whenever stall_out was low at the edge
    task automatic tick();
        logic s;
        @(negedge clk);
        s = stall_out;
        @(posedge clk);
        #1;
        if (!s && fq.size() > 0) fq.delete(0);
        present();
        if (rnd_ready && hold_cnt == 0 && $urandom_range(0, 31) == 0) hold_cnt = $urandom_range(1, 5);
        if (hold_cnt > 0) begin ifc.out_ready = 1'b0; hold_cnt--; end
        else ifc.out_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    endtask

    task automatic drain(input int budget);
        int c;
        c = 0;
        while ((fq.size() > 0 || exp_q.size() > 0 || rd_t >= 0 || m_valid) && c < budget) begin
            tick(); c++;
        end
        if (fq.size() > 0 || exp_q.size() > 0 || rd_t >= 0 || m_valid) begin
            n_chk++; n_fail++;
            $display("FAIL drain_timeout: %0d packets pending after %0d cycles, expected 0", exp_q.size(), c);
        end
        repeat (2) tick();
    endtask

    function automatic fetch_t rand_fetch();
        fetch_t f;
        logic [7:0] op;
        case ($urandom_range(0, 7))
            0: op = 8'h00;
            1: op = 8'h03;
            2: op = 8'h04;
            3: op = 8'h13;
            4: op = 8'h11;
            5: op = 8'h19;
            6: op = 8'h1A;
            default: op = 8'($urandom);
        endcase
        f.inst = $urandom;
        f.inst[7:0] = op;
        f.base = $urandom;
        return f;
    endfunction

    initial begin
        ifc.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) tick();

        push(32'h0000_0003, 32'h0000_0104);
        drain(40);

        push(32'h0000_0013, 32'h0000_0020);
        drain(60);

        // Back-pressure on a count-0 packet, followed by an operand command
        push(32'h0000_0019, 32'h0);
        push(32'h0000_0004, 32'h0000_0200);
        hold_cnt = 6;
        ifc.out_ready = 1'b0;
        drain(60);

        repeat (10) fq.push_back('{inst: 32'h0, base: 32'h0});
        present();
        drain(40);

        // Reset during the second READ cycle of a LOADMATRIX
        push(32'h0000_0013, 32'h0000_0020);
        begin
            int c;
            c = 0;
            while (rd_t != 1 && c < 20) begin tick(); c++; end
            if (rd_t != 1) begin
                n_chk++; n_fail++;
                $display("FAIL read_start_timeout: rd index %0d expected 1", rd_t);
            end
        end
        #2 reset = 1'b1;
        #1;
        check("async_rst_valid", ifc.out_valid, 0);
        check("async_rst_stall", stall_out, 0);
        check("async_rst_operands", ifc.out_operands, 0);
        fq.delete();
        present();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        push(32'h0000_0003, 32'h0000_0300);
        push(32'h0000_0003, 32'h0000_0310);
        drain(40);

`ifdef GL_DECODE_ERR_EN
        push(32'h0000_007F, 32'h0);
        push(32'h0000_0003, 32'h0000_0400);
        push(32'h0000_0004, 32'h0000_0500);
        drain(60);
        check("err_sticky", err, 1);
`endif

        rnd_ready = 1'b1;
        for (int i = 0; i < 250; i++) fq.push_back(rand_fetch());
        present();
        drain(20000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #600_000;
        $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
